jtopl_wrqueue: RTL and testbench

- Host-side write scheduler in front of the OPL register port (the block carrying din/addr/cs_n/wr_n).
- Buffers CPU register writes in a small FIFO and replays them to the chip port, honouring OPL inter-write recovery times: address phase 12 ticks, data phase 84 ticks, counted in cen ticks.
- Lets a fast CPU or sound driver write back-to-back without polling a busy flag.

---
 rtl/jtopl_wrqueue_pkg.sv | 20 ++
 rtl/jtopl_wrqueue_if.sv | 22 ++
 rtl/jtopl_wrqueue_fifo.sv | 65 ++++++
 rtl/jtopl_wrqueue.sv | 127 ++++++++++++
 tb/tb_jtopl_wrqueue.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/jtopl_wrqueue_pkg.sv
// Shared types and timing constants for the OPL write queue.
package jtopl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT
    } wrq_state_e;

    localparam int OPL_ADDR_WAIT = 12;
    localparam int OPL_DATA_WAIT = 84;

    // Width able to hold max(a,d)-1, never below one bit
    function automatic int cnt_width(int a, int d);
        int m;
        m = (a > d) ? a : d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/jtopl_wrqueue_if.sv
// Host-side write port of the OPL write queue.
interface jtopl_wrqueue_if #(
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          h_wr;
    logic          h_addr;
    logic [7:0]    h_din;
    logic          h_full;
    logic [LW-1:0] h_level;

    modport master (
        output h_wr, h_addr, h_din,
        input  h_full, h_level
    );

    modport slave (
        input  h_wr, h_addr, h_din,
        output h_full, h_level
    );
endinterface

// File: rtl/jtopl_wrqueue_fifo.sv
// Synchronous FIFO with occupancy count; full is taken from
// the pre-edge level, so a push while full is always refused.
module jtopl_wrqueue_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_L = LW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [LW-1:0] lvl_q, lvl_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (lvl_q == FULL_L);
    assign empty_o = (lvl_q == '0);
    assign level_o = lvl_q;
    assign dout_o  = mem[rd_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        lvl_d = lvl_q;
        if (push_ok) wr_d = wr_q + 1'b1;
        if (pop_ok)  rd_d = rd_q + 1'b1;
        unique case ({push_ok, pop_ok})
            2'b10:   lvl_d = lvl_q + 1'b1;
            2'b01:   lvl_d = lvl_q - 1'b1;
            default: lvl_d = lvl_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_q] <= din_i;
    end

endmodule

// File: rtl/jtopl_wrqueue.sv
// Buffers host writes and replays them to the OPL port with recovery gaps.
// Optional JTOPL_WRQUEUE_OVFCNT_EN builds a saturating dropped-write counter.
module jtopl_wrqueue
    import jtopl_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int ADDR_WAIT = OPL_ADDR_WAIT,
    parameter int DATA_WAIT = OPL_DATA_WAIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    jtopl_wrqueue_if.slave   h,
    output logic             busy,
    output logic             ovf,
    output logic [7:0]       opl_din,
    output logic             opl_addr,
    output logic             opl_cs_n,
    output logic             opl_wr_n,
    output logic [7:0]       ovf_cnt
);
    localparam int CW = cnt_width(ADDR_WAIT, DATA_WAIT);
    localparam logic [CW-1:0] AW_L = CW'(ADDR_WAIT - 1);
    localparam logic [CW-1:0] DW_L = CW'(DATA_WAIT - 1);

    wrq_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    din_q, din_d;
    logic          addr_q, addr_d;
    logic          strb_q, strb_d;
    logic          ovf_q;
    logic          pop;
    logic          full;
    logic          empty;
    logic          rej;
    logic [8:0]    head;
    logic [$clog2(DEPTH):0] level;

    jtopl_wrqueue_fifo #(
        .DEPTH (DEPTH),
        .W     (9)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (h.h_wr),
        .din_i   ({h.h_addr, h.h_din}),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    assign h.h_full  = full;
    assign h.h_level = level;
    assign rej       = h.h_wr & full;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        addr_d  = addr_q;
        strb_d  = strb_q;
        pop     = 1'b0;
        if (cen) begin
            unique case (state_q)
                IDLE: begin
                    if (!empty) begin
                        {addr_d, din_d} = head;
                        strb_d  = 1'b1;
                        pop     = 1'b1;
                        state_d = STROBE;
                    end
                end
                STROBE: begin
                    strb_d  = 1'b0;
                    cnt_d   = addr_q ? DW_L : AW_L;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            din_q   <= '0;
            addr_q  <= 1'b0;
            strb_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            ovf_q   <= ovf_q | rej;
        end
    end

    assign opl_din  = din_q;
    assign opl_addr = addr_q;
    assign opl_cs_n = ~strb_q;
    assign opl_wr_n = ~strb_q;
    assign ovf      = ovf_q;
    assign busy     = (state_q != IDLE) | (level != '0);

`ifdef JTOPL_WRQUEUE_OVFCNT_EN
    logic [7:0] ocnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n)                     ocnt_q <= '0;
        else if (rej && ocnt_q != 8'hff) ocnt_q <= ocnt_q + 8'd1;
    end

    assign ovf_cnt = ocnt_q;
`else
    assign ovf_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_jtopl_wrqueue.sv
// Randomized bench for jtopl_wrqueue against a cen-tick timing model.
module tb_jtopl_wrqueue;
    localparam int DEPTH = 8;
    localparam int AW    = 12;
    localparam int DW    = 84;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       busy, ovf, opl_addr, opl_cs_n, opl_wr_n;
    logic [7:0] opl_din, ovf_cnt;

    jtopl_wrqueue_if #(.DEPTH(DEPTH)) hif ();

    jtopl_wrqueue #(
        .DEPTH     (DEPTH),
        .ADDR_WAIT (AW),
        .DATA_WAIT (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .h        (hif.slave),
        .busy     (busy),
        .ovf      (ovf),
        .opl_din  (opl_din),
        .opl_addr (opl_addr),
        .opl_cs_n (opl_cs_n),
        .opl_wr_n (opl_wr_n),
        .ovf_cnt  (ovf_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: queue of writes, plus the cen tick at which
    // the port may next be strobed.
    logic [8:0] q[$];
    int         ct;
    int         next_ok;
    bit         m_strb;
    logic [7:0] m_din;
    logic       m_addr;
    bit         m_ovf;
    int         m_ocnt;

    task automatic chk(string tag, int unsigned act, int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ct      = 0;
        next_ok = 0;
        m_strb  = 0;
        m_din   = '0;
        m_addr  = 1'b0;
        m_ovf   = 0;
        m_ocnt  = 0;
    endtask

    task automatic step(bit wr, bit a, logic [7:0] d, bit c, bit rn);
        logic [8:0] e;
        bit         was_full;
        int         exp_oc;
        hif.h_wr   = wr;
        hif.h_addr = a;
        hif.h_din  = d;
        cen        = c;
        rst_n      = rn;
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else begin
            was_full = (q.size() == DEPTH);
            if (c) begin
                m_strb = 0;
                if (ct >= next_ok && q.size() > 0) begin
                    e = q.pop_front();
                    {m_addr, m_din} = e;
                    m_strb  = 1;
                    next_ok = ct + (m_addr ? DW : AW) + 2;
                end
                ct++;
            end
            if (wr) begin
                if (was_full) begin
                    m_ovf = 1;
                    if (m_ocnt < 255) m_ocnt++;
                end else begin
                    q.push_back({a, d});
                end
            end
        end
        #1;
`ifdef JTOPL_WRQUEUE_OVFCNT_EN
        exp_oc = m_ocnt;
`else
        exp_oc = 0;
`endif
        chk("cs_n",  opl_cs_n, !m_strb);
        chk("wr_n",  opl_wr_n, !m_strb);
        chk("din",   opl_din, m_din);
        chk("addr",  opl_addr, m_addr);
        chk("level", hif.h_level, q.size());
        chk("full",  hif.h_full, q.size() == DEPTH);
        chk("busy",  busy, (q.size() != 0) || (ct < next_ok));
        chk("ovf",   ovf, m_ovf);
        chk("ocnt",  ovf_cnt, exp_oc);
    endtask

    task automatic idle(int n, bit c);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, c, 1);
    endtask

    initial begin
        hif.h_wr   = 1'b0;
        hif.h_addr = 1'b0;
        hif.h_din  = '0;
        model_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0);

        // single address write
        step(1, 0, 8'h20, 1, 1);
        idle(20, 1);

        // back-to-back address/data/address
        step(1, 0, 8'h40, 1, 1);
        step(1, 1, 8'h3F, 1, 1);
        step(1, 0, 8'h60, 1, 1);
        idle(120, 1);

        // overflow with cen held low, then replay
        for (int i = 0; i < 10; i++)
            step(1, $urandom_range(0, 1), 8'(8'hA0 + i), 0, 1);
        idle(800, 1);

        // cen every 4th clk
        step(1, 1, 8'h55, 0, 1);
        step(1, 0, 8'h66, 0, 1);
        for (int i = 0; i < 480; i++) step(0, 0, 8'h00, (i % 4) == 3, 1);

        // reset while strobing with writes queued
        for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h10 + i), 0, 1);
        for (int i = 0; i < 8 && !m_strb; i++) step(0, 0, 8'h00, 1, 1);
        step(0, 0, 8'h00, 1, 0);
        idle(30, 1);

        // push while full at a pop edge, then random traffic
        for (int i = 0; i < 9; i++) step(1, 0, 8'(i), 0, 1);
        step(1, 1, 8'hEE, 1, 1);
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 1),
                 8'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 699) != 0);
        idle(200, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
